// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one combinational alu between NREQ requesters
//   clk_i, rst_i           clock, synchronous active-high reset
//   req_valid_i/req_ready_o per-requester handshake; req_a_i/req_b_i packed k*N, req_op_i packed k*3
//   alu_a_o/alu_b_o/alu_opcode_o, alu_result_i/alu_flags_i  drive to and result from the alu
//   rsp_valid_o/rsp_ready_i, rsp_id_o/rsp_result_o/rsp_flags_o  registered, id-tagged response
//   ALU_ARB_FIXED_PRIO_EN  when defined: fixed priority (lowest index wins), no rotating pointer
module alu_arbiter #(
  parameter int N = 4,
  parameter int NREQ = 4,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NREQ-1:0]   req_valid_i,
  output logic [NREQ-1:0]   req_ready_o,
  input  logic [NREQ*N-1:0] req_a_i,
  input  logic [NREQ*N-1:0] req_b_i,
  input  logic [NREQ*3-1:0] req_op_i,
  output logic [N-1:0]      alu_a_o,
  output logic [N-1:0]      alu_b_o,
  output logic [2:0]        alu_opcode_o,
  input  logic [N-1:0]      alu_result_i,
  input  logic [1:0]        alu_flags_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [IDW-1:0]    rsp_id_o,
  output logic [N-1:0]      rsp_result_o,
  output logic [1:0]        rsp_flags_o
);
  logic issue_en, hit, grant;
  logic [IDW-1:0] win;
  logic rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [N-1:0] rsp_result_q, rsp_result_d;
  logic [1:0] rsp_flags_q, rsp_flags_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
  localparam logic [IDW:0] nreq_w = (IDW+1)'(NREQ);
  logic [IDW-1:0] ptr_q, ptr_d, idx;
  logic [IDW:0] ofs;
`endif
  // Scanning from the far end down means the last hit is the first in search order.
  always_comb begin
    hit = 1'b0;
    win = '0;
`ifdef ALU_ARB_FIXED_PRIO_EN
    for (int i = NREQ-1; i >= 0; i--) begin
      if (req_valid_i[i]) begin
        hit = 1'b1;
        win = IDW'(i);
      end
    end
`else
    ofs = '0;
    idx = '0;
    for (int i = NREQ-1; i >= 0; i--) begin
      ofs = {1'b0, ptr_q} + (IDW+1)'(i);
      idx = IDW'(ofs >= nreq_w ? ofs - nreq_w : ofs);
      if (req_valid_i[idx]) begin
        hit = 1'b1;
        win = idx;
      end
    end
`endif
  end
  assign issue_en     = !rsp_valid_q || rsp_ready_i;
  assign grant        = hit && issue_en && !rst_i;
  assign req_ready_o  = grant ? NREQ'(1) << win : '0;
  assign alu_a_o      = grant ? req_a_i[win*N +: N] : '0;
  assign alu_b_o      = grant ? req_b_i[win*N +: N] : '0;
  assign alu_opcode_o = grant ? req_op_i[win*3 +: 3] : '0;
  always_comb begin
    rsp_valid_d  = grant ? 1'b1 : (rsp_ready_i ? 1'b0 : rsp_valid_q);
    rsp_id_d     = grant ? win : rsp_id_q;
    rsp_result_d = grant ? alu_result_i : rsp_result_q;
    rsp_flags_d  = grant ? alu_flags_i : rsp_flags_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
    ptr_d        = grant ? (win == IDW'(NREQ-1) ? '0 : win + 1'b1) : ptr_q;
`endif
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      ptr_q        <= '0;
`endif
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
      ptr_q        <= ptr_d;
`endif
    end
  end
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_id_o     = rsp_id_q;
  assign rsp_result_o = rsp_result_q;
  assign rsp_flags_o  = rsp_flags_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench for alu_arbiter with a small alu model
module tb_alu_arbiter;
  localparam int N = 4, NREQ = 4, IDW = 2;
  localparam logic [2:0] SUM = 3'd0, RES = 3'd1;
`ifdef ALU_ARB_FIXED_PRIO_EN
  localparam bit fixed = 1'b1;
`else
  localparam bit fixed = 1'b0;
`endif
  logic clk_i = 1'b0, rst_i = 1'b1;
  logic [NREQ-1:0] req_valid_i = '0, req_ready_o;
  logic [NREQ*N-1:0] req_a_i = '0, req_b_i = '0;
  logic [NREQ*3-1:0] req_op_i = '0;
  logic [N-1:0] alu_a_o, alu_b_o, alu_result_i, rsp_result_o;
  logic [2:0] alu_opcode_o;
  logic [1:0] alu_flags_i, rsp_flags_o;
  logic rsp_valid_o, rsp_ready_i = 1'b1;
  logic [IDW-1:0] rsp_id_o;
  int n_cmp = 0, n_err = 0;
  int g;
  alu_arbiter #(.N(N), .NREQ(NREQ)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_a_i(req_a_i), .req_b_i(req_b_i), .req_op_i(req_op_i),
    .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_opcode_o(alu_opcode_o),
    .alu_result_i(alu_result_i), .alu_flags_i(alu_flags_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_id_o(rsp_id_o), .rsp_result_o(rsp_result_o), .rsp_flags_o(rsp_flags_o)
  );
  always #5 clk_i = ~clk_i;
  always_comb begin
    alu_result_i = alu_opcode_o == RES ? alu_a_o - alu_b_o : alu_a_o + alu_b_o;
    alu_flags_i  = {alu_result_i[N-1], alu_result_i == '0};
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask
  task automatic set_req(input int k, input logic [N-1:0] a, input logic [N-1:0] b, input logic [2:0] op);
    req_a_i[k*N +: N] = a;
    req_b_i[k*N +: N] = b;
    req_op_i[k*3 +: 3] = op;
  endtask
  initial begin
    for (int k = 0; k < NREQ; k++) set_req(k, N'(k+1), 4'd1, SUM);
    req_valid_i = 4'b1111;
    tick();
    tick();
    chk("rst_ready", req_ready_o, 0);
    chk("rst_valid", rsp_valid_o, 0);
    chk("rst_id", rsp_id_o, 0);
    chk("rst_result", rsp_result_o, 0);
    chk("rst_flags", rsp_flags_o, 0);
    chk("rst_alu_a", alu_a_o, 0);
    rst_i = 1'b0;
    #1;
    chk("first_ready", req_ready_o, 4'b0001);
    chk("first_alu_a", alu_a_o, 1);
    tick();
    chk("first_valid", rsp_valid_o, 1);
    chk("first_id", rsp_id_o, 0);
    chk("first_result", rsp_result_o, 2);
    set_req(2, 4'd3, 4'd4, SUM);
    req_valid_i = 4'b0100;
    #1;
    chk("single_ready", req_ready_o, 4'b0100);
    chk("single_alu_a", alu_a_o, 3);
    chk("single_alu_b", alu_b_o, 4);
    chk("single_op", alu_opcode_o, SUM);
    tick();
    chk("single_valid", rsp_valid_o, 1);
    chk("single_id", rsp_id_o, 2);
    chk("single_result", rsp_result_o, 7);
    chk("single_flags", rsp_flags_o, 2'b00);
    set_req(1, 4'd5, 4'd5, RES);
    req_valid_i = 4'b0010;
    #1;
    chk("zero_ready", req_ready_o, 4'b0010);
    chk("zero_op", alu_opcode_o, RES);
    tick();
    chk("zero_id", rsp_id_o, 1);
    chk("zero_result", rsp_result_o, 0);
    chk("zero_flags", rsp_flags_o, 2'b01);
    set_req(1, 4'd2, 4'd6, SUM);
    #1;
    chk("neg_ready", req_ready_o, 4'b0010);
    tick();
    chk("neg_result", rsp_result_o, 8);
    chk("neg_flags", rsp_flags_o, 2'b10);
    rst_i = 1'b1;
    req_valid_i = '0;
    tick();
    rst_i = 1'b0;
    for (int k = 0; k < NREQ; k++) set_req(k, N'(k+1), 4'd1, SUM);
    req_valid_i = 4'b1111;
    #1;
    for (int i = 0; i < 6; i++) begin
      g = fixed ? 0 : i % 4;
      chk("rr_ready", req_ready_o, 32'd1 << g);
      tick();
      chk("rr_id", rsp_id_o, g);
      chk("rr_result", rsp_result_o, g + 2);
      #1;
    end
    rsp_ready_i = 1'b0;
    #1;
    chk("bp_ready0", req_ready_o, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_ready", req_ready_o, 0);
      chk("bp_alu_a", alu_a_o, 0);
      chk("bp_valid", rsp_valid_o, 1);
      chk("bp_id", rsp_id_o, fixed ? 0 : 1);
      chk("bp_result", rsp_result_o, fixed ? 2 : 3);
    end
    rsp_ready_i = 1'b1;
    #1;
    chk("bp_release_ready", req_ready_o, fixed ? 4'b0001 : 4'b0100);
    chk("bp_release_alu_a", alu_a_o, fixed ? 1 : 3);
    tick();
    chk("bp_release_valid", rsp_valid_o, 1);
    chk("bp_release_id", rsp_id_o, fixed ? 0 : 2);
    chk("bp_release_result", rsp_result_o, fixed ? 2 : 4);
    rsp_ready_i = 1'b0;
    rst_i = 1'b1;
    req_valid_i = 4'b1010;
    #1;
    chk("mid_rst_ready", req_ready_o, 0);
    chk("mid_rst_alu_a", alu_a_o, 0);
    tick();
    chk("mid_rst_valid", rsp_valid_o, 0);
    chk("mid_rst_id", rsp_id_o, 0);
    chk("mid_rst_result", rsp_result_o, 0);
    rst_i = 1'b0;
    #1;
    chk("mid_first_ready", req_ready_o, 4'b0010);
    tick();
    chk("mid_first_valid", rsp_valid_o, 1);
    chk("mid_first_id", rsp_id_o, 1);
    chk("mid_first_result", rsp_result_o, 3);
    #1;
    chk("mid_bp_ready", req_ready_o, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
